// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: fetch-stage control bundle between the pipeline (master) and the fetch controller (slave)
interface fetch_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      pc_4;
  logic             if_br;
  logic [31:0]      br_tgt_if;
  logic             jump_id;
  logic [31:0]      jump_tgt_id;
  logic             is_br_ex;
  logic             branch_ex;
  logic [31:0]      br_tgt_ex;
  logic [31:0]      br_fall_ex;
  logic             haz_stall;
  logic             imem_rdy;
  logic [31:0]      next_pc;
  logic             pc_we;
  logic             flush_if;
  logic             flush_id;
  logic             predict_taken;
  logic [CNT_W-1:0] mispred_cnt;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output pc_4, if_br, br_tgt_if, jump_id, jump_tgt_id, is_br_ex, branch_ex,
           br_tgt_ex, br_fall_ex, haz_stall, imem_rdy,
    input  next_pc, pc_we, flush_if, flush_id, predict_taken, mispred_cnt, stall_cnt
  );
  modport slave (
    input  pc_4, if_br, br_tgt_if, jump_id, jump_tgt_id, is_br_ex, branch_ex,
           br_tgt_ex, br_fall_ex, haz_stall, imem_rdy,
    output next_pc, pc_we, flush_if, flush_id, predict_taken, mispred_cnt, stall_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: next-PC selection, flush control and 2-bit branch predictor; FETCH_PERF_CNT_EN adds perf counters
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter logic [1:0]  PRED_INIT = 2'b01,
  parameter int          CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, WAIT, WAIT_PEND} state_t;
  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] pend_q, pend_d;
  logic        pred_id_q, pred_id_d, pred_ex_q, pred_ex_d;
  logic        predict, mispred, adv, we, fif, fid;
  logic [31:0] fix_pc, nxt;
  assign predict = bus.if_br & cnt_q[1];
  assign mispred = bus.is_br_ex & (bus.branch_ex != pred_ex_q);
  assign fix_pc  = bus.branch_ex ? bus.br_tgt_ex : bus.br_fall_ex;
  assign adv     = we & ~bus.haz_stall;
  // redirect priority and FSM; WAIT with memory ready behaves exactly like RUN
  always_comb begin
    nxt     = bus.pc_4;
    we      = 1'b0;
    fif     = 1'b0;
    fid     = 1'b0;
    state_d = state_q;
    pend_d  = pend_q;
    if (state_q == WAIT_PEND) begin
      if (bus.imem_rdy) begin
        nxt     = mispred ? fix_pc : pend_q;
        we      = 1'b1;
        fif     = 1'b1;
        fid     = mispred;
        state_d = RUN;
      end else if (mispred) begin
        pend_d = fix_pc;
        fif    = 1'b1;
        fid    = 1'b1;
      end
    end else if (mispred) begin
      fif     = 1'b1;
      fid     = 1'b1;
      nxt     = fix_pc;
      we      = bus.imem_rdy;
      pend_d  = bus.imem_rdy ? pend_q : fix_pc;
      state_d = bus.imem_rdy ? RUN : WAIT_PEND;
    end else if (!bus.imem_rdy) begin
      state_d = WAIT;
    end else begin
      state_d = RUN;
      we      = ~bus.haz_stall;
      fif     = ~bus.haz_stall & bus.jump_id;
      nxt     = bus.haz_stall ? bus.pc_4 : bus.jump_id ? bus.jump_tgt_id : predict ? bus.br_tgt_if : bus.pc_4;
    end
  end
  // prediction pipe and saturating predictor; prediction above uses the pre-update counter
  always_comb begin
    pred_id_d = fif ? 1'b0 : adv ? predict : pred_id_q;
    pred_ex_d = (fid | bus.haz_stall) ? 1'b0 : adv ? pred_id_q : pred_ex_q;
    cnt_d     = !bus.is_br_ex ? cnt_q :
                bus.branch_ex ? cnt_q + {1'b0, cnt_q != 2'd3} : cnt_q - {1'b0, cnt_q != 2'd0};
  end
  // control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cnt_q     <= PRED_INIT;
      pend_q    <= '0;
      pred_id_q <= 1'b0;
      pred_ex_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pred_id_q <= pred_id_d;
      pred_ex_q <= pred_ex_d;
    end
  end
  assign bus.next_pc       = rst_n ? nxt : RESET_PC;
  assign bus.pc_we         = rst_n & we;
  assign bus.flush_if      = ~rst_n | fif;
  assign bus.flush_id      = ~rst_n | fid;
  assign bus.predict_taken = rst_n & predict;
`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] mis_q, mis_d, stl_q, stl_d;
  // saturating mispredict and stall-cycle counters
  always_comb begin
    mis_d = mis_q + CNT_W'(mispred & ~&mis_q);
    stl_d = stl_q + CNT_W'(~we & ~&stl_q);
  end
  // counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= '0;
      stl_q <= '0;
    end else begin
      mis_q <= mis_d;
      stl_q <= stl_d;
    end
  end
  assign bus.mispred_cnt = mis_q;
  assign bus.stall_cnt   = stl_q;
`else
  assign bus.mispred_cnt = '0;
  assign bus.stall_cnt   = '0;
`endif
endmodule
